gsim_mat_mem_ctrl: RTL and testbench
====================================

# gsim_mat_mem_ctrl

Read-responder for the GSIM matrix-memory interface. It serves the solver's 256-bit row reads from a single-port SRAM with a fixed, parameterised latency, and drives the `rrdy`/`dout_vld` side of the handshake. It also provides a host preload port that fills the SRAM with coefficient and `b` rows before `i_module_en` rises. It sits between the GSIM core and the matrix SRAM macro.

## Interface
Parameters:
- `ADDR_W`, default 10: request address width.
- `DATA_W`, default 256: row width (16 × 16-bit entries).
- `DEPTH`, default 544: valid rows (32 matrices × 17 rows); addresses ≥ `DEPTH` are out of range.
- `RD_LAT`, default 1: SRAM read latency in cycles, legal range 1..4.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`  in  1  clock
- `i_reset`  in  1  asynchronous active-high reset
- `i_mem_rreq`  in  1  read request from the solver
- `i_mem_addr`  in  ADDR_W  row address, valid while `i_mem_rreq` is high
- `o_mem_rrdy`  out  1  responder can accept a request this cycle
- `o_mem_dout`  out  DATA_W  read data, registered and held between responses
- `o_mem_dout_vld`  out  1  one-cycle pulse marking `o_mem_dout` valid
- `i_wr_en`  in  1  host preload write
- `i_wr_addr`  in  ADDR_W  preload address
- `i_wr_data`  in  DATA_W  preload data
- `o_wr_rdy`  out  1  preload write accepted this cycle
- `o_sram_en`  out  1  SRAM access enable
- `o_sram_we`  out  1  SRAM write enable (1 = write)
- `o_sram_addr`  out  ADDR_W  SRAM address
- `o_sram_wdata`  out  DATA_W  SRAM write data
- `i_sram_rdata`  in  DATA_W  SRAM read data, valid `RD_LAT` cycles after a read enable
- `o_err`  out  1  sticky out-of-range flag

## Operation
- FSM states:
  - `S_IDLE`: free.
  - `S_WAIT`: read in flight; a latency counter runs.
  - `S_RESP`: `o_mem_dout_vld` is 1; the block is also free.
- Free means the state is `S_IDLE` or `S_RESP`.
  - `o_wr_rdy` = free.
  - `o_mem_rrdy` = free && !`i_wr_en`. Writes have priority over reads.
- Read accept: `i_mem_rreq` && `o_mem_rrdy` at a rising edge.
  - In that same cycle, drive combinationally: `o_sram_en`=1, `o_sram_we`=0, `o_sram_addr`=`i_mem_addr`.
  - Next state is `S_WAIT`, with the counter loaded to `RD_LAT`-1.
- `S_WAIT`:
  - Decrement the counter each cycle.
  - At 0, capture `i_sram_rdata` into `o_mem_dout` and go to `S_RESP`.
- `S_RESP`:
  - Lasts one cycle unless a new read is accepted, which goes to `S_WAIT` (back-to-back).
  - Otherwise go to `S_IDLE`, or stay free if a write is accepted.
- Out-of-range read (`i_mem_addr` ≥ `DEPTH`):
  - No SRAM access.
  - Same latency as a normal read; `o_mem_dout` = 0.
  - `o_err` is set.
- Write accept: `i_wr_en` && `o_wr_rdy`.
  - `o_sram_en`=1, `o_sram_we`=1, address and data are passed through combinationally.
  - An out-of-range write is dropped and sets `o_err`.
- `i_mem_rreq` while `o_mem_rrdy`=0 is ignored. The requester must hold the request until it is accepted.
- `i_wr_en` while `o_wr_rdy`=0 is ignored. The host must hold the write.
- `o_err` clears only on reset.

## Timing
- Reset values: `o_mem_rrdy`=1 (combinational, `S_IDLE`), `o_wr_rdy`=1, `o_mem_dout`=0, `o_mem_dout_vld`=0, `o_err`=0, SRAM controls=0.
- Read latency: accept at edge T, so `o_mem_dout_vld`=1 during cycle T+`RD_LAT`+1.
  - With `RD_LAT`=1, the pulse appears 2 cycles after accept.
- Throughput: one read per `RD_LAT`+1 cycles (a new accept is allowed in the `S_RESP` cycle).
- Write: 1 cycle, no response pulse.
- Read-after-write to the same address returns the new data (the write completes before the read is issued).
- Reset mid-read: the pending response is discarded, no `o_mem_dout_vld` pulse is produced, and `o_mem_dout` returns to 0.
- Counter width: 2 bits covers `RD_LAT` ≤ 4.

## Structure
- Shared package `gsim_pkg`: `ADDR_W`, `DATA_W`, `DEPTH`, `ROWS_PER_MAT`=17, and the state enum `S_IDLE`/`S_WAIT`/`S_RESP`. The solver's address computation (17·mat + row) uses the same `ROWS_PER_MAT`.
- One natural sub-module: `gsim_sram_model`, a behavioural `DEPTH`×`DATA_W` single-port SRAM with `RD_LAT` output pipeline. It is used by the bench and by top-level simulation; the controller itself contains no storage.

## Test plan
- Preload rows 0..16 with pattern `{16{addr[15:0]}}`, then read address 5 with `RD_LAT`=1 → `o_mem_rrdy` drops after accept, `o_mem_dout_vld` pulses exactly 2 cycles later, and `o_mem_dout`=`{16{16'h0005}}`.
- Hold `i_mem_rreq` continuously over addresses 0..16 → 17 pulses spaced every 2 cycles, data in address order, and `o_mem_dout` held between pulses.
- Assert `i_wr_en` and `i_mem_rreq` together in `S_IDLE` → write taken and `o_mem_rrdy`=0 that cycle; the read is accepted next cycle and returns the just-written data.
- Read address 600 → pulse at normal latency, `o_mem_dout`=0, `o_err`=1 and stays 1 through later good reads until `i_reset`.
- Assert `i_reset` one cycle after a read accept with `RD_LAT`=3 → no `o_mem_dout_vld` pulse; all outputs at reset values; `o_mem_rrdy`=1 immediately after reset releases.
- Sweep `RD_LAT`=1..4 with random addresses < 544 against the scoreboard → every accept produces exactly one pulse at `RD_LAT`+1 with matching data.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared definitions for the GSIM matrix-memory path.
//   ADDR_W/DATA_W/DEPTH : default geometry of the matrix SRAM
//   ROWS_PER_MAT        : rows per matrix (16 coefficient rows + 1 b row)
//   state_e             : read-responder FSM states
//   row_addr()          : 17*mat + row, the same address map the solver uses
package gsim_pkg;
  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 256;
  localparam int DEPTH        = 544;
  localparam int ROWS_PER_MAT = 17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [4:0] mat,
                                                 input logic [4:0] row);
    return ADDR_W'(int'(mat) * ROWS_PER_MAT + int'(row));
  endfunction
endpackage

// File: rtl/gsim_sram_model.sv
// Behavioural single-port SRAM, DEPTH x DATA_W, with an RD_LAT-stage read
// pipeline. Used in simulation next to gsim_mat_mem_ctrl.
//   i_clk    : clock
//   i_en     : access enable
//   i_we     : 1 = write, 0 = read
//   i_addr   : row address
//   i_wdata  : write data
//   o_rdata  : read data, valid RD_LAT cycles after a read enable
module gsim_sram_model #(
  parameter int ADDR_W = gsim_pkg::ADDR_W,
  parameter int DATA_W = gsim_pkg::DATA_W,
  parameter int DEPTH  = gsim_pkg::DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] pipe_q [RD_LAT];
  logic              in_range;

  assign in_range = ({1'b0, i_addr} < DEPTH_C);

  always_ff @(posedge i_clk) begin
    if (i_en && i_we && in_range) begin
      mem_q[i_addr] <= i_wdata;
    end
    if (i_en && !i_we && in_range) begin
      pipe_q[0] <= mem_q[i_addr];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign o_rdata = pipe_q[RD_LAT-1];
endmodule

// File: rtl/gsim_mat_mem_ctrl.sv
// Read-responder for the GSIM matrix memory plus host preload port.
// Serves one solver row read at a time from an external single-port SRAM
// with fixed latency RD_LAT; host writes share the SRAM port and win over
// reads. Holds no storage of its own.
//   i_clk/i_reset              : clock, async active-high reset
//   i_mem_rreq/i_mem_addr      : solver read request (held until accepted)
//   o_mem_rrdy                 : read can be accepted this cycle
//   o_mem_dout/o_mem_dout_vld  : registered read data, one-cycle valid pulse
//   i_wr_en/i_wr_addr/i_wr_data: host preload write (held until accepted)
//   o_wr_rdy                   : write accepted this cycle
//   o_sram_*/i_sram_rdata      : SRAM macro port
//   o_err                      : sticky out-of-range access flag
//
// Handshake: a read transfers on a rising edge where i_mem_rreq and
// o_mem_rrdy are both 1, a write where i_wr_en and o_wr_rdy are both 1;
// the requester keeps request and payload stable until that edge, and a
// request seen while the matching ready is 0 has no effect.
module gsim_mat_mem_ctrl #(
  parameter int ADDR_W = gsim_pkg::ADDR_W,
  parameter int DATA_W = gsim_pkg::DATA_W,
  parameter int DEPTH  = gsim_pkg::DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_rreq,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              o_mem_rrdy,
  output logic [DATA_W-1:0] o_mem_dout,
  output logic              o_mem_dout_vld,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_rdy,
  output logic              o_sram_en,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_err
);
  import gsim_pkg::*;

  localparam logic [1:0]      LAT_M1  = 2'(RD_LAT - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oor_q, oor_d;   // read in flight is out of range
  logic              err_q, err_d;

  logic free, wr_acc, rd_acc, wr_oor, rd_oor;

  assign free       = (state_q != S_WAIT);
  assign o_wr_rdy   = free;
  assign o_mem_rrdy = free && !i_wr_en;
  assign wr_acc     = i_wr_en && free;
  assign rd_acc     = i_mem_rreq && o_mem_rrdy;
  assign wr_oor     = ({1'b0, i_wr_addr} >= DEPTH_C);
  assign rd_oor     = ({1'b0, i_mem_addr} >= DEPTH_C);

  // SRAM port: out-of-range accesses never reach the macro.
  always_comb begin
    o_sram_en    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (wr_acc && !wr_oor) begin
      o_sram_en    = 1'b1;
      o_sram_we    = 1'b1;
      o_sram_addr  = i_wr_addr;
      o_sram_wdata = i_wr_data;
    end else if (rd_acc && !rd_oor) begin
      o_sram_en   = 1'b1;
      o_sram_addr = i_mem_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    oor_d   = oor_q;
    err_d   = err_q | (wr_acc && wr_oor) | (rd_acc && rd_oor);
    case (state_q)
      S_IDLE, S_RESP: begin
        if (rd_acc) begin
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
          oor_d   = rd_oor;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          // Out-of-range reads keep normal latency but return zeros.
          dout_d  = oor_q ? '0 : i_sram_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      oor_q   <= oor_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_dout     = dout_q;
  assign o_mem_dout_vld = (state_q == S_RESP);
  assign o_err          = err_q;
endmodule

// File: tb/tb_gsim_mat_mem_ctrl.sv
// Bench for gsim_mat_mem_ctrl: four lanes, each a controller plus SRAM
// model, with RD_LAT = 1..4. A reference memory per lane and a timing
// model (pulse RD_LAT+1 cycles after accept, busy in between) predict
// every output cycle by cycle.
module tb_gsim_mat_mem_ctrl;
  import gsim_pkg::*;

  localparam int NL     = 4;
  localparam int BUDGET = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              rreq    [NL];
  logic [ADDR_W-1:0] raddr   [NL];
  logic              rrdy    [NL];
  logic [DATA_W-1:0] dout    [NL];
  logic              vld     [NL];
  logic              wr_en   [NL];
  logic [ADDR_W-1:0] waddr   [NL];
  logic [DATA_W-1:0] wdata   [NL];
  logic              wr_rdy  [NL];
  logic              s_en    [NL];
  logic              s_we    [NL];
  logic [ADDR_W-1:0] s_addr  [NL];
  logic [DATA_W-1:0] s_wdata [NL];
  logic [DATA_W-1:0] s_rdata [NL];
  logic              err     [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    gsim_mat_mem_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(g + 1)
    ) u_dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_mem_rreq     (rreq[g]),
      .i_mem_addr     (raddr[g]),
      .o_mem_rrdy     (rrdy[g]),
      .o_mem_dout     (dout[g]),
      .o_mem_dout_vld (vld[g]),
      .i_wr_en        (wr_en[g]),
      .i_wr_addr      (waddr[g]),
      .i_wr_data      (wdata[g]),
      .o_wr_rdy       (wr_rdy[g]),
      .o_sram_en      (s_en[g]),
      .o_sram_we      (s_we[g]),
      .o_sram_addr    (s_addr[g]),
      .o_sram_wdata   (s_wdata[g]),
      .i_sram_rdata   (s_rdata[g]),
      .o_err          (err[g])
    );
    gsim_sram_model #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(g + 1)
    ) u_sram (
      .i_clk   (clk),
      .i_en    (s_en[g]),
      .i_we    (s_we[g]),
      .i_addr  (s_addr[g]),
      .i_wdata (s_wdata[g]),
      .o_rdata (s_rdata[g])
    );
  end

  // Reference model
  logic [DATA_W-1:0] ref_mem  [NL][DEPTH];
  logic              ref_err  [NL];
  logic [DATA_W-1:0] ref_dout [NL];
  logic [ADDR_W-1:0] req_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_row();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic string tg(input string s, input int ln);
    return $sformatf("%s[lat%0d]", s, ln + 1);
  endfunction

  task automatic check_reset_values();
    for (int ln = 0; ln < NL; ln++) begin
      check(tg("rst_rrdy", ln), rrdy[ln], 1'b1);
      check(tg("rst_wr_rdy", ln), wr_rdy[ln], 1'b1);
      check(tg("rst_dout", ln), dout[ln], '0);
      check(tg("rst_vld", ln), vld[ln], 1'b0);
      check(tg("rst_err", ln), err[ln], 1'b0);
      check(tg("rst_sram_en", ln), s_en[ln], 1'b0);
    end
  endtask

  // One-cycle host write on an idle lane.
  task automatic do_write(input int ln, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    logic in_rng;
    in_rng = (int'(a) < DEPTH);
    wr_en[ln] = 1'b1; waddr[ln] = a; wdata[ln] = d;
    #1;
    check(tg("wr_rdy", ln), wr_rdy[ln], 1'b1);
    check(tg("wr_rrdy_blocked", ln), rrdy[ln], 1'b0);
    check(tg("wr_sram_en", ln), s_en[ln], in_rng);
    check(tg("wr_sram_we", ln), s_we[ln], in_rng);
    tick();
    wr_en[ln] = 1'b0;
    if (in_rng) ref_mem[ln][a] = d;
    else ref_err[ln] = 1'b1;
  endtask

  // Issues every address in req_q on lane ln, holding each request until
  // accepted (rnd adds random idle gaps), and checks every output cycle.
  task automatic run_reads(input int ln, input bit rnd);
    int                lat;
    int                cyc;
    int                last_acc;
    bit                req_on;
    int                due_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] a;
    logic              exp_rrdy;
    lat = ln + 1; cyc = 0; last_acc = -100; req_on = 1'b0;
    while ((req_q.size() > 0 || due_q.size() > 0) && cyc < BUDGET) begin
      if (!req_on && req_q.size() > 0)
        req_on = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      a = (req_q.size() > 0) ? req_q[0] : '0;
      rreq[ln]  = req_on;
      raddr[ln] = req_on ? a : ADDR_W'($urandom_range(0, DEPTH - 1));
      #1;
      exp_rrdy = !(cyc > last_acc && cyc <= last_acc + lat);
      check(tg("rrdy", ln), rrdy[ln], exp_rrdy);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        ref_dout[ln] = exp_q.pop_front();
        check(tg("vld_pulse", ln), vld[ln], 1'b1);
      end else begin
        check(tg("vld_quiet", ln), vld[ln], 1'b0);
      end
      check(tg("dout", ln), dout[ln], ref_dout[ln]);
      check(tg("err", ln), err[ln], ref_err[ln]);
      if (req_on && exp_rrdy) begin
        due_q.push_back(cyc + lat + 1);
        if (int'(a) < DEPTH) begin
          exp_q.push_back(ref_mem[ln][a]);
        end else begin
          exp_q.push_back('0);
          ref_err[ln] = 1'b1;
        end
        last_acc = cyc;
        req_on   = 1'b0;
        void'(req_q.pop_front());
      end
      tick();
      cyc++;
    end
    rreq[ln] = 1'b0;
    check(tg("read_budget_ok", ln), (cyc < BUDGET), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [15:0]       a16;
    rst = 1'b1;
    for (int ln = 0; ln < NL; ln++) begin
      rreq[ln] = 1'b0; raddr[ln] = '0; wr_en[ln] = 1'b0;
      waddr[ln] = '0; wdata[ln] = '0;
      ref_err[ln] = 1'b0; ref_dout[ln] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // Preload: rows 0..16 get {16{addr}}, the rest random.
    for (int ln = 0; ln < NL; ln++) begin
      for (int a = 0; a < DEPTH; a++) begin
        a16 = 16'(a);
        d = (a < ROWS_PER_MAT) ? {16{a16}} : rand_row();
        do_write(ln, ADDR_W'(a), d);
      end
    end

    // Single read of row 5 on the RD_LAT=1 lane.
    req_q.push_back(ADDR_W'(5));
    run_reads(0, 1'b0);
    check("row5_data", dout[0], {16{16'h0005}});

    // Back-to-back stream over rows 0..16.
    for (int a = 0; a < ROWS_PER_MAT; a++) req_q.push_back(ADDR_W'(a));
    run_reads(0, 1'b0);

    // Write and read together: write wins, read follows with new data.
    d = rand_row();
    rreq[0] = 1'b1; raddr[0] = ADDR_W'(7);
    wr_en[0] = 1'b1; waddr[0] = ADDR_W'(7); wdata[0] = d;
    #1;
    check("wr_rd_rrdy", rrdy[0], 1'b0);
    check("wr_rd_wr_rdy", wr_rdy[0], 1'b1);
    check("wr_rd_sram_we", s_we[0], 1'b1);
    check("wr_rd_sram_addr", s_addr[0], ADDR_W'(7));
    tick();
    wr_en[0] = 1'b0;
    ref_mem[0][7] = d;
    req_q.push_back(ADDR_W'(7));
    run_reads(0, 1'b0);
    check("raw_data", dout[0], d);

    // Out-of-range read then good reads; err stays set.
    req_q.push_back(ADDR_W'(600));
    req_q.push_back(ADDR_W'(3));
    req_q.push_back(ADDR_W'(9));
    run_reads(0, 1'b0);
    check("oor_err_sticky", err[0], 1'b1);

    // Out-of-range write is dropped but flags err.
    do_write(1, ADDR_W'(700), rand_row());

    // Randomised sweep across all latencies.
    for (int ln = 0; ln < NL; ln++) begin
      for (int i = 0; i < 30; i++)
        req_q.push_back(ADDR_W'($urandom_range(0, DEPTH - 1)));
      run_reads(ln, 1'b1);
    end

    // Reset one cycle after an accept on the RD_LAT=3 lane.
    rreq[2] = 1'b1; raddr[2] = ADDR_W'(5);
    #1;
    check("mid_rst_accept_rrdy", rrdy[2], 1'b1);
    tick();
    rreq[2] = 1'b0;
    #1;
    check("mid_rst_busy_rrdy", rrdy[2], 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_reset_values();
    tick();
    tick();
    rst = 1'b0;
    for (int ln = 0; ln < NL; ln++) begin
      ref_err[ln] = 1'b0; ref_dout[ln] = '0;
    end
    #1;
    check("post_rst_rrdy", rrdy[2], 1'b1);
    for (int k = 0; k < 6; k++) begin
      check("post_rst_no_vld", vld[2], 1'b0);
      check("post_rst_dout", dout[2], '0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
